// File: rtl/fir_tap_line_if.sv
// Sample-in / taps-out bundle for the multi-channel FIR tap delay line.
// Handshake: a sample transfers on any rising edge with in_valid=1 and clear=0; the line is always ready (no backpressure).
interface fir_tap_line_if #(
  parameter int NUM_TAPS   = 4,
  parameter int DATA_WIDTH = 18,
  parameter int NUM_CH     = 2
);
  localparam int CNT_W = $clog2(NUM_TAPS + 1);

  logic                                  clear;
  logic                                  in_valid;
  logic [NUM_CH*DATA_WIDTH-1:0]          data_in;
  logic [NUM_CH*NUM_TAPS*DATA_WIDTH-1:0] taps_out;
  logic                                  taps_valid;
  logic                                  primed;
  logic [CNT_W-1:0]                      fill_count;

  modport master (
    output clear, in_valid, data_in,
    input  taps_out, taps_valid, primed, fill_count
  );

  modport slave (
    input  clear, in_valid, data_in,
    output taps_out, taps_valid, primed, fill_count
  );
endinterface

// File: rtl/fir_tap_line.sv
// Multi-channel tap delay line with fill tracking, synchronous flush and a
// decimated window-valid strobe for the downstream FIR/correlator MACs.
module fir_tap_line #(
  parameter int NUM_TAPS   = 4,
  parameter int DATA_WIDTH = 18,
  parameter int NUM_CH     = 2,
  parameter int DECIM      = 1
) (
  input logic           clk,
  input logic           rst_n,
  fir_tap_line_if.slave bus
);
  localparam int CNT_W  = $clog2(NUM_TAPS + 1);
  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int TAPS_W = NUM_CH * NUM_TAPS * DATA_WIDTH;
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(NUM_TAPS);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(DECIM - 1);

  logic [TAPS_W-1:0] taps_q, taps_d;
  logic [CNT_W-1:0]  fill_q, fill_d, fill_next;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              valid_q, valid_d;
  logic              accept;

  assign accept    = bus.in_valid & ~bus.clear;
  assign fill_next = (fill_q == FULL) ? FULL : fill_q + CNT_W'(1);

  always_comb begin
    taps_d  = taps_q;
    fill_d  = fill_q;
    phase_d = phase_q;
    valid_d = 1'b0;
    if (bus.clear) begin
      taps_d  = '0;
      fill_d  = '0;
      phase_d = '0;
    end else if (accept) begin
      for (int c = 0; c < NUM_CH; c++) begin
        taps_d[(c*NUM_TAPS)*DATA_WIDTH +: DATA_WIDTH] = bus.data_in[c*DATA_WIDTH +: DATA_WIDTH];
        for (int k = 1; k < NUM_TAPS; k++) begin
          taps_d[(c*NUM_TAPS+k)*DATA_WIDTH +: DATA_WIDTH] =
            taps_q[(c*NUM_TAPS+k-1)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      fill_d = fill_next;
      // Phase only runs once the window is full, so the first strobe lands on the completing sample.
      if (fill_next == FULL) begin
        valid_d = (phase_q == '0);
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_q  <= '0;
      fill_q  <= '0;
      phase_q <= '0;
      valid_q <= 1'b0;
    end else begin
      taps_q  <= taps_d;
      fill_q  <= fill_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
    end
  end

  assign bus.taps_out   = taps_q;
  assign bus.taps_valid = valid_q;
  assign bus.primed     = (fill_q == FULL);
  assign bus.fill_count = fill_q;
endmodule

// File: tb/tb_fir_tap_line.sv
// Self-checking bench for fir_tap_line: a 4-tap/2-ch/DECIM=2 instance and an
// 8-tap/1-ch/DECIM=1 instance, both checked against a queue-based window model.
module tb_fir_tap_line;
  localparam int DW  = 18;
  localparam int NTA = 4, NCA = 2, DCA = 2;
  localparam int NTB = 8, NCB = 1, DCB = 1;
  localparam int WA  = NCA * DW, WB = NCB * DW;
  localparam int TWA = NCA * NTA * DW, TWB = NCB * NTB * DW;

  logic clk = 1'b0;
  logic rst_n_a, rst_n_b;
  int   checks = 0;
  int   errors = 0;

  fir_tap_line_if #(.NUM_TAPS(NTA), .DATA_WIDTH(DW), .NUM_CH(NCA)) bus_a ();
  fir_tap_line_if #(.NUM_TAPS(NTB), .DATA_WIDTH(DW), .NUM_CH(NCB)) bus_b ();

  fir_tap_line #(.NUM_TAPS(NTA), .DATA_WIDTH(DW), .NUM_CH(NCA), .DECIM(DCA)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(bus_a.slave)
  );
  fir_tap_line #(.NUM_TAPS(NTB), .DATA_WIDTH(DW), .NUM_CH(NCB), .DECIM(DCB)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(bus_b.slave)
  );

  always #5 clk = ~clk;

  // Reference model: the window is simply the last NUM_TAPS accepted samples, newest first.
  logic [WA-1:0] hist_a[$];
  logic [WB-1:0] hist_b[$];
  int            cnt_a, cnt_b;
  logic          exp_tv_a, exp_tv_b;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WA-1:0] pat_a(input int n);
    logic [DW-1:0] c0;
    c0 = {n[7:0], 10'b0};
    return {~c0, c0};
  endfunction

  function automatic logic [TWA-1:0] exp_taps_a();
    logic [TWA-1:0] v;
    logic [WA-1:0]  s;
    v = '0;
    for (int k = 0; k < hist_a.size(); k++) begin
      s = hist_a[k];
      for (int c = 0; c < NCA; c++) v[(c*NTA+k)*DW +: DW] = s[c*DW +: DW];
    end
    return v;
  endfunction

  function automatic logic [TWB-1:0] exp_taps_b();
    logic [TWB-1:0] v;
    v = '0;
    for (int k = 0; k < hist_b.size(); k++) v[k*DW +: DW] = hist_b[k];
    return v;
  endfunction

  task automatic model_a(input logic valid, input logic clr, input logic [WA-1:0] d);
    if (clr) begin
      hist_a.delete(); cnt_a = 0; exp_tv_a = 1'b0;
    end else if (valid) begin
      hist_a.push_front(d);
      if (hist_a.size() > NTA) void'(hist_a.pop_back());
      cnt_a++;
      exp_tv_a = (cnt_a >= NTA) && (((cnt_a - NTA) % DCA) == 0);
    end else begin
      exp_tv_a = 1'b0;
    end
  endtask

  task automatic model_b(input logic valid, input logic clr, input logic [WB-1:0] d);
    if (clr) begin
      hist_b.delete(); cnt_b = 0; exp_tv_b = 1'b0;
    end else if (valid) begin
      hist_b.push_front(d);
      if (hist_b.size() > NTB) void'(hist_b.pop_back());
      cnt_b++;
      exp_tv_b = (cnt_b >= NTB) && (((cnt_b - NTB) % DCB) == 0);
    end else begin
      exp_tv_b = 1'b0;
    end
  endtask

  task automatic check_a(input string tag);
    chk({tag, ".taps"},   256'(bus_a.taps_out),   256'(exp_taps_a()));
    chk({tag, ".tvalid"}, 256'(bus_a.taps_valid), 256'(exp_tv_a));
    chk({tag, ".primed"}, 256'(bus_a.primed),     256'(cnt_a >= NTA));
    chk({tag, ".fill"},   256'(bus_a.fill_count), 256'((cnt_a > NTA) ? NTA : cnt_a));
  endtask

  task automatic check_b(input string tag);
    chk({tag, ".taps"},   256'(bus_b.taps_out),   256'(exp_taps_b()));
    chk({tag, ".tvalid"}, 256'(bus_b.taps_valid), 256'(exp_tv_b));
    chk({tag, ".primed"}, 256'(bus_b.primed),     256'(cnt_b >= NTB));
    chk({tag, ".fill"},   256'(bus_b.fill_count), 256'((cnt_b > NTB) ? NTB : cnt_b));
  endtask

  // Driver: present inputs, let one edge pass, update the model, check #1 later.
  task automatic step_a(input string tag, input logic valid, input logic clr, input logic [WA-1:0] d);
    bus_a.in_valid = valid;
    bus_a.clear    = clr;
    bus_a.data_in  = d;
    @(posedge clk);
    model_a(valid, clr, d);
    #1;
    check_a(tag);
  endtask

  task automatic step_b(input string tag, input logic valid, input logic clr, input logic [WB-1:0] d);
    bus_b.in_valid = valid;
    bus_b.clear    = clr;
    bus_b.data_in  = d;
    @(posedge clk);
    model_b(valid, clr, d);
    #1;
    check_b(tag);
  endtask

  task automatic reset_a();
    bus_a.in_valid = 1'b0; bus_a.clear = 1'b0; bus_a.data_in = '0;
    rst_n_a = 1'b0;
    model_a(1'b0, 1'b1, '0);
    repeat (2) @(posedge clk);
    #1;
    check_a("reset");
    rst_n_a = 1'b1;
  endtask

  task automatic fill_a(input string tag);
    for (int n = 1; n <= 4; n++) step_a(tag, 1'b1, 1'b0, pat_a(n));
    chk({tag, ".tap0"}, 256'(bus_a.taps_out[0*DW +: DW]), 256'(18'h01000));
    chk({tag, ".tap1"}, 256'(bus_a.taps_out[1*DW +: DW]), 256'(18'h00C00));
    chk({tag, ".tap2"}, 256'(bus_a.taps_out[2*DW +: DW]), 256'(18'h00800));
    chk({tag, ".tap3"}, 256'(bus_a.taps_out[3*DW +: DW]), 256'(18'h00400));
    chk({tag, ".pulse4"}, 256'(bus_a.taps_valid), 256'(1'b1));
  endtask

  initial begin
    logic [63:0] r;
    int          pulses_b;
    bus_b.in_valid = 1'b0; bus_b.clear = 1'b0; bus_b.data_in = '0;
    rst_n_b = 1'b0;
    model_b(1'b0, 1'b1, '0);

    // Scenario 1: reset, then fill with n=1..4
    reset_a();
    fill_a("s1");

    // Scenario 2: decimation, n=5..9 back-to-back
    for (int n = 5; n <= 9; n++) step_a("s2", 1'b1, 1'b0, pat_a(n));

    // Scenario 3: gaps 1,0,0,1 with n=10,11
    step_a("s3", 1'b1, 1'b0, pat_a(10));
    step_a("s3", 1'b0, 1'b0, pat_a(99));
    step_a("s3", 1'b0, 1'b0, pat_a(98));
    step_a("s3", 1'b1, 1'b0, pat_a(11));
    step_a("s3", 1'b1, 1'b0, pat_a(12));

    // Scenario 4: clear wins over a simultaneous sample, then refill
    step_a("s4clr", 1'b1, 1'b1, pat_a(12));
    chk("s4.taps_zero", 256'(bus_a.taps_out), 256'(0));
    for (int n = 13; n <= 16; n++) step_a("s4refill", 1'b1, 1'b0, pat_a(n));

    // Scenario 5: async reset between edges while primed
    bus_a.in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n_a = 1'b0;
    model_a(1'b0, 1'b1, '0);
    #1;
    check_a("s5async");
    repeat (2) @(posedge clk);
    #1;
    check_a("s5held");
    rst_n_a = 1'b1;
    fill_a("s5refill");

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      r = {$urandom(), $urandom()};
      step_a("rand_a", ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), r[WA-1:0]);
    end

    // Scenario 6: 8-tap single-channel DECIM=1 instance, 20 accepts
    bus_a.in_valid = 1'b0;
    rst_n_b = 1'b1;
    @(posedge clk);
    #1;
    check_b("s6reset");
    pulses_b = 0;
    for (int i = 0; i < 20; i++) begin
      r = {$urandom(), $urandom()};
      step_b("s6", 1'b1, 1'b0, r[WB-1:0]);
      if (bus_b.taps_valid === 1'b1) pulses_b++;
    end
    chk("s6.pulse_count", 256'(pulses_b), 256'(13));
    for (int i = 0; i < 60; i++) begin
      r = {$urandom(), $urandom()};
      step_b("rand_b", ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0), r[WB-1:0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_tap_line.md
# fir_tap_line

Parametrised multi-channel tap delay line feeding the modem's FIR filter and correlator datapaths. Each accepted input sample shifts into a per-channel shift register whose every tap is exposed in parallel. The block adds what the earlier fixed delay line lacked:
- an input-valid strobe;
- fill tracking (primed flag and count);
- synchronous flush;
- a decimating output strobe, so a downstream MAC evaluates only every DECIM-th sample.

Sits between the sample source (ADC/NCO mixer, I and Q) and the filter arithmetic.

## Interface
- NUM_TAPS, 4: taps per channel; ≥2.
- DATA_WIDTH, 18: bits per sample (Q8.10 in the modem).
- NUM_CH, 2: independent channels sharing one strobe (I, Q).
- DECIM, 1: output strobe decimation factor; ≥1.
- CNT_W, $clog2(NUM_TAPS+1): width of fill_count (derived, not overridden).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush.
- in_valid  in  1  sample strobe; data_in accepted on a rising edge where in_valid=1 and clear=0.
- data_in  in  NUM_CH*DATA_WIDTH  channel c at [c*DATA_WIDTH +: DATA_WIDTH].
- taps_out  out  NUM_CH*NUM_TAPS*DATA_WIDTH  channel c, tap k at [(c*NUM_TAPS+k)*DATA_WIDTH +: DATA_WIDTH]; tap 0 = newest.
- taps_valid  out  1  one-cycle pulse: taps_out holds a full, decimation-selected window.
- primed  out  1  line holds NUM_TAPS valid samples since last reset/clear.
- fill_count  out  CNT_W  accepted samples since reset/clear, saturating at NUM_TAPS.

## Operation
- Accept (in_valid=1, clear=0): for every channel, tap0 ← data_in slice, tap k ← tap k−1 for k=1..NUM_TAPS−1; oldest sample discarded. Channels shift in lockstep.
- No accept: all taps hold.
- Fill: fill_next = min(fill_count+1, NUM_TAPS) on accept; primed = (fill_count == NUM_TAPS), combinational from fill_count.
- Decimation phase counter `phase` (0..DECIM−1, internal):
  - Stays 0 while fill_next < NUM_TAPS.
  - On an accept with fill_next == NUM_TAPS: taps_valid ← (phase == 0); phase ← (phase == DECIM−1) ? 0 : phase+1.
  - First taps_valid fires on the sample that completes the window, then every DECIM-th accepted sample.
  - DECIM=1: every accepted sample once primed.
- taps_valid ← 0 on any cycle without an accept.
- clear=1: all taps, fill_count, phase, taps_valid ← 0 next edge.
  - Priority over in_valid; a sample presented with clear is dropped.
- No arithmetic on data; samples pass bit-exact, no sign extension or rounding.

## Timing
- Reset (rst_n=0, async assert, sync release on clk): taps_out = 0, taps_valid = 0, primed = 0, fill_count = 0, phase = 0.
- Reset mid-operation discards all content immediately; no output glitches to stale data after deassertion.
- Latency: sample accepted at edge N appears on tap 0 after edge N; on tap k after k further accepts.
- taps_valid is registered, asserted for exactly the cycle after the accepting edge, aligned with the updated taps_out.
- Back-to-back in_valid every cycle is supported at full rate; gaps are arbitrary and do not advance phase.
- Saturation: fill_count never exceeds NUM_TAPS; continued accepts keep primed=1.
- clear and rst_n both override everything; clear while primed drops primed the next cycle.

## Test plan
Bench parameters: NUM_TAPS=4, DATA_WIDTH=18, NUM_CH=2, DECIM=2. Ch0 sample = {n[7:0],10'b0}; ch1 = ~ch0.

1. Reset then fill: rst_n low 2 cycles, then 4 consecutive accepts n=1..4.
   - fill_count steps 1,2,3,4; primed=1 after the 4th edge.
   - ch0 taps (0..3) = 0x1000,0x0C00,0x0800,0x0400 (n=4,3,2,1).
   - taps_valid pulses once, after accept 4.
2. Decimation: continue n=5..9 back-to-back.
   - taps_valid=1 after accepts 6 and 8 only; 0 after 5, 7, 9.
   - ch1 tap0 = ~ch0 tap0 every cycle.
3. Gaps: in_valid pattern 1,0,0,1 with n=10,11.
   - Taps hold during idle cycles; taps_valid=0 during gaps.
   - Phase resumes, so the next pulse lands on the correct 2nd accepted sample.
4. Clear with simultaneous valid: clear=1, in_valid=1, n=12.
   - Next cycle: all taps 0, fill_count=0, primed=0, taps_valid=0; n=12 absent.
   - Refill with 4 samples → first taps_valid on the 4th.
5. Async reset mid-stream: drop rst_n between edges while primed.
   - Outputs zero before the next clk edge.
   - After release, behaviour identical to scenario 1.
6. Regression at DECIM=1, NUM_TAPS=8, NUM_CH=1: 20 accepts.
   - taps_valid on accepts 8..20 (13 pulses).
   - tap7 equals the sample from 7 accepts earlier.
